// File: rtl/jtopll_wrctl.sv
// OPLL CPU write front-end: latches address/data writes and schedules one-rotation update strobes.
// Optional rhythm register (0x0E) decode is enabled by defining JTOPLL_RHYTHM_EN.
module jtopll_wrctl #(
  parameter int SLOTS = 18
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       zero,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout_reg,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_original,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_rhythm,
  output logic       busy,
  output logic       overrun
);
  typedef enum logic [2:0] {K_ORIG, K_FLO, K_FHI, K_INST, K_RHY} kind_t;
  typedef enum logic [1:0] {IDLE, PEND, ACTIVE} state_t;
  typedef struct packed {
    kind_t       kind;
    logic [1:0]  group;
    logic [2:0]  sub;
    logic [7:0]  data;
  } rec_t;

  localparam logic [7:0] LAST_TICK = 8'(SLOTS - 1);

  state_t     state;
  rec_t       cur, pbuf, rec;
  logic       pbuf_full, wr_last, wr_act, wr_edge, rec_ok, valid, tick;
  logic [7:0] areg, tick_cnt;
  logic [4:0] up_q;
  logic [3:0] anib;

  assign wr_act  = ~cs_n & ~wr_n;
  assign wr_edge = wr_act & ~wr_last;
  assign tick    = cen & zero;
  assign anib    = areg[3:0];
  assign valid   = wr_edge & addr & rec_ok;

  function automatic logic [4:0] onehot(kind_t k);
    return 5'b1 << k;
  endfunction

  // Register number comes from the latched address, payload from the data bus.
  always_comb begin
    rec      = '0;
    rec_ok   = 1'b0;
    rec.data = din;
    if (areg[7:3] == 5'd0) begin
      rec_ok   = 1'b1;
      rec.kind = K_ORIG;
      rec.sub  = areg[2:0];
    end else if (areg[7:4] >= 4'd1 && areg[7:4] <= 4'd3 && anib <= 4'd8) begin
      rec_ok    = 1'b1;
      rec.kind  = kind_t'({1'b0, areg[5:4]});
      rec.group = 2'(anib / 4'd3);
      rec.sub   = 3'(anib % 4'd3);
    end
`ifdef JTOPLL_RHYTHM_EN
    else if (areg == 8'h0E) begin
      rec_ok   = 1'b1;
      rec.kind = K_RHY;
      rec.data = {2'b00, din[5:0]};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      pbuf      <= '0;
      pbuf_full <= 1'b0;
      wr_last   <= 1'b0;
      areg      <= '0;
      up_q      <= '0;
      overrun   <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      wr_last  <= wr_act;
      if (wr_edge && !addr) areg <= din;
      tick_cnt <= tick ? 8'd0 : (cen ? tick_cnt + 8'd1 : tick_cnt);
      case (state)
        IDLE: if (valid) begin
          cur   <= rec;
          state <= PEND;
        end
        PEND: begin
          if (tick) begin
            state <= ACTIVE;
            up_q  <= onehot(cur.kind);
          end
          if (valid) begin
            pbuf      <= rec;
            pbuf_full <= 1'b1;
            if (pbuf_full) overrun <= 1'b1;
          end
        end
        ACTIVE: if (tick) begin
          // Buffer moves to the slot before a same-cycle write can land in it.
          if (pbuf_full) begin
            cur       <= pbuf;
            up_q      <= onehot(pbuf.kind);
            pbuf_full <= valid;
            if (valid) pbuf <= rec;
          end else begin
            up_q <= '0;
            if (valid) begin
              cur   <= rec;
              state <= PEND;
            end else begin
              state <= IDLE;
            end
          end
        end else if (valid) begin
          pbuf      <= rec;
          pbuf_full <= 1'b1;
          if (pbuf_full) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  act_len: assert property (@(posedge clk) disable iff (rst)
    (tick && state == ACTIVE) |-> (tick_cnt == LAST_TICK));

  assign up_original = up_q[0];
  assign up_fnumlo   = up_q[1];
  assign up_fnumhi   = up_q[2];
  assign up_inst     = up_q[3];
  assign up_rhythm   = up_q[4];
  assign sel_group   = cur.group;
  assign sel_sub     = cur.sub;
  assign dout_reg    = cur.data;
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_jtopll_wrctl.sv
// Bench for jtopll_wrctl: vector table, corner sequences and a queue-based reference model.
module tb_jtopll_wrctl;
  logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, zero = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout_reg;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_original, up_fnumlo, up_fnumhi, up_inst, up_rhythm, busy, overrun;
  logic [4:0] upv;

  int n_vec = 0, n_bad = 0;
  int slot = 0;

`ifdef JTOPLL_RHYTHM_EN
  localparam bit RHY = 1'b1;
`else
  localparam bit RHY = 1'b0;
`endif

  jtopll_wrctl #(.SLOTS(18)) dut (
    .rst(rst), .clk(clk), .cen(cen), .zero(zero), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .dout_reg(dout_reg), .sel_group(sel_group),
    .sel_sub(sel_sub), .up_original(up_original), .up_fnumlo(up_fnumlo),
    .up_fnumhi(up_fnumhi), .up_inst(up_inst), .up_rhythm(up_rhythm),
    .busy(busy), .overrun(overrun)
  );

  assign upv = {up_rhythm, up_inst, up_fnumhi, up_fnumlo, up_original};

  always #5 clk = ~clk;

  // Slot counter: zero marks slot 0 on a cen tick; zero is noise when cen is low.
  initial forever begin
    @(negedge clk);
    cen = ($urandom_range(0, 3) != 0);
    if (cen) begin
      zero = (slot == 0);
      slot = (slot == 17) ? 0 : slot + 1;
    end else begin
      zero = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one update runs per rotation; at most two updates are
  // owned by the block (running + waiting), and the newest waiting one is replaced.
  typedef struct {int kind; int grp; int sub; int data;} mrec_t;
  mrec_t q[$];
  mrec_t m_act;
  bit    m_act_v = 0, m_ovr = 0, m_prev = 0;
  int    m_areg = 0;

  function automatic bit decode(input int a, input int d, output mrec_t r);
    r = '{0, 0, 0, d};
    if (a < 8) begin r.sub = a; return 1'b1; end
    if (a / 16 >= 1 && a / 16 <= 3 && a % 16 <= 8) begin
      r.kind = a / 16; r.grp = (a % 16) / 3; r.sub = (a % 16) % 3;
      return 1'b1;
    end
    if (a == 14 && RHY) begin r.kind = 4; r.data = d % 64; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit act, wedge, hw;
    mrec_t w;
    act   = !cs_n && !wr_n;
    wedge = act && !m_prev;
    m_prev = act;
    hw = 1'b0;
    if (wedge && addr) hw = decode(m_areg, int'(din), w);
    if (wedge && !addr) m_areg = int'(din);
    if (cen && zero) begin
      m_act_v = 1'b0;
      if (q.size() > 0) begin m_act = q.pop_front(); m_act_v = 1'b1; end
    end
    if (hw) begin
      if (int'(m_act_v) + q.size() >= 2) begin
        q[q.size() - 1] = w;
        m_ovr = 1'b1;
      end else begin
        q.push_back(w);
      end
    end
  endtask

  task automatic model_check();
    logic [4:0] eu;
    mrec_t r;
    bit eb;
    eb = m_act_v || (q.size() > 0);
    eu = m_act_v ? 5'(1 << m_act.kind) : 5'b0;
    chk("model_up", upv, eu);
    chk("model_busy", busy, eb);
    chk("model_overrun", overrun, m_ovr);
    if (eb) begin
      if (m_act_v) r = m_act; else r = q[0];
      chk("model_sel", {sel_group, sel_sub, dout_reg}, {2'(r.grp), 3'(r.sub), 8'(r.data)});
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_act_v = 1'b0; m_ovr = 1'b0; m_prev = 1'b0; m_areg = 0;
    end else begin
      model_step();
      #1;
      if (!rst) model_check();
    end
  end

  task automatic wr(input bit a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    repeat (hold) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (cen && zero) break;
    end
  endtask

  task automatic wait_strobe();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 120 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (upv != 5'b0);
    end
    chk("strobe_seen", ok, 1'b1);
  endtask

  // Counts cen ticks while the current update (strobe + record) stays unchanged.
  task automatic measure(output int ticks);
    logic [17:0] first;
    first = {upv, sel_group, sel_sub, dout_reg};
    ticks = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cen) ticks++;
      if ({upv, sel_group, sel_sub, dout_reg} != first) break;
    end
  endtask

  typedef struct {
    logic [7:0] a, d;
    bit         hit;
    logic [4:0] up;
    logic [1:0] grp;
    logic [2:0] sub;
    logic [7:0] dout;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int ticks, bad;
    bit saw;
    logic [7:0] ra;

    tbl[0] = '{8'h35, 8'h47, 1'b1, 5'b01000, 2'd1, 3'd2, 8'h47};
    tbl[1] = '{8'h02, 8'hA5, 1'b1, 5'b00001, 2'd0, 3'd2, 8'hA5};
    tbl[2] = '{8'h19, 8'h33, 1'b0, 5'b00000, 2'd0, 3'd0, 8'h00};
    tbl[3] = '{8'h50, 8'h33, 1'b0, 5'b00000, 2'd0, 3'd0, 8'h00};
    tbl[4] = '{8'h18, 8'h7C, 1'b1, 5'b00010, 2'd2, 3'd2, 8'h7C};
    tbl[5] = '{8'h24, 8'h5A, 1'b1, 5'b00100, 2'd1, 3'd1, 8'h5A};
    tbl[6] = '{8'h07, 8'hFF, 1'b1, 5'b00001, 2'd0, 3'd7, 8'hFF};
    tbl[7] = '{8'h0E, 8'h20, RHY, RHY ? 5'b10000 : 5'b0, 2'd0, 3'd0, 8'h20};
    tbl[8] = '{8'h3A, 8'h11, 1'b0, 5'b00000, 2'd0, 3'd0, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_up", upv, 5'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_sel", {sel_group, sel_sub, dout_reg}, 13'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      wait_tick();
      wr(1'b0, tbl[i].a, 1);
      wr(1'b1, tbl[i].d, 1);
      if (tbl[i].hit) begin
        wait_strobe();
        chk("vec_up", upv, tbl[i].up);
        chk("vec_group", sel_group, tbl[i].grp);
        chk("vec_sub", sel_sub, tbl[i].sub);
        chk("vec_dout", dout_reg, tbl[i].dout);
        measure(ticks);
        chk("vec_len", ticks, 18);
        chk("vec_drop", upv, 5'b0);
        chk("vec_busy_drop", busy, 1'b0);
      end else begin
        saw = 1'b0;
        repeat (40) begin
          @(posedge clk); #1;
          saw |= (upv != 5'b0) || busy;
        end
        chk("vec_discard", saw, 1'b0);
      end
    end

    // Back-to-back updates inside one rotation run with no gap.
    wait_tick();
    wr(1'b0, 8'h10, 1); wr(1'b1, 8'h11, 1);
    wr(1'b0, 8'h20, 1); wr(1'b1, 8'h22, 1);
    wait_strobe();
    chk("b2b_first_up", upv, 5'b00010);
    chk("b2b_first_sel", {sel_group, sel_sub, dout_reg}, {2'd0, 3'd0, 8'h11});
    measure(ticks);
    chk("b2b_first_len", ticks, 18);
    chk("b2b_second_up", upv, 5'b00100);
    chk("b2b_second_sel", {sel_group, sel_sub, dout_reg}, {2'd0, 3'd0, 8'h22});
    chk("b2b_overrun", overrun, 1'b0);
    measure(ticks);
    chk("b2b_second_len", ticks, 18);
    chk("b2b_idle", busy, 1'b0);

    // Three writes while pending: first kept, last buffered, overrun set.
    wait_tick();
    wr(1'b0, 8'h16, 1);
    wr(1'b1, 8'h01, 1); wr(1'b1, 8'h02, 1); wr(1'b1, 8'h03, 1);
    chk("ovr_flag", overrun, 1'b1);
    wait_strobe();
    chk("ovr_first", {upv, sel_group, sel_sub, dout_reg}, {5'b00010, 2'd2, 3'd0, 8'h01});
    measure(ticks);
    chk("ovr_first_len", ticks, 18);
    chk("ovr_second", {upv, sel_group, sel_sub, dout_reg}, {5'b00010, 2'd2, 3'd0, 8'h03});
    measure(ticks);
    chk("ovr_done", busy, 1'b0);

    // Asynchronous reset while a strobe is high.
    wr(1'b0, 8'h35, 1); wr(1'b1, 8'h47, 1);
    wait_strobe();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_up", upv, 5'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_overrun", overrun, 1'b0);
    chk("arst_sel", {sel_group, sel_sub, dout_reg}, 13'd0);
    @(negedge clk) rst = 1'b0;

    // Random bus traffic against the model.
    bad = n_bad;
    repeat (500) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0) begin
        @(posedge clk); #3 rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end else if (r < 6) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end else if (r < 8) begin
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b0; addr = 1'b1; din = 8'($urandom);
        @(negedge clk);
        wr_n = 1'b1;
      end else begin
        if ($urandom_range(0, 5) == 0) ra = 8'($urandom);
        else if ($urandom_range(0, 7) == 0) ra = 8'h0E;
        else ra = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 3) != 0) wr(1'b0, ra, $urandom_range(1, 3));
        wr(1'b1, 8'($urandom), $urandom_range(1, 3));
      end
    end
    repeat (60) @(negedge clk);
    chk("random_clean", n_bad - bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
